// File: rtl/vigna_bus_arbiter.sv
// Merges the vigna core's instruction and data ports onto a single memory port,
// one outstanding transaction at a time, with registered request and response paths.
module vigna_bus_arbiter #(
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    output logic [31:0]           i_rdata,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic [31:0]           d_rdata,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    input  logic [31:0]           m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    state_e                state_q,      state_d;
    port_e                 last_grant_q, last_grant_d;
    logic                  m_valid_q,    m_valid_d;
    logic [ADDR_WIDTH-1:0] m_addr_q,     m_addr_d;
    logic [31:0]           m_wdata_q,    m_wdata_d;
    logic [3:0]            m_wstrb_q,    m_wstrb_d;
    logic                  i_ready_q,    i_ready_d;
    logic                  d_ready_q,    d_ready_d;
    logic [31:0]           i_rdata_q,    i_rdata_d;
    logic [31:0]           d_rdata_q,    d_rdata_d;
    logic                  take_d;

    // D wins when alone, under fixed priority, or when I was served last.
    assign take_d = d_valid && (!i_valid || (ROUND_ROBIN == 0) || (last_grant_q == PORT_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_d   = REQ;
                    m_valid_d = 1'b1;
                    if (take_d) begin
                        last_grant_d = PORT_D;
                        m_addr_d     = d_addr;
                        m_wdata_d    = d_wdata;
                        m_wstrb_d    = d_wstrb;
                    end else begin
                        last_grant_d = PORT_I;
                        m_addr_d     = i_addr;
                        m_wdata_d    = i_wdata;
                        m_wstrb_d    = i_wstrb;
                    end
                end
            end
            REQ: begin
                if (m_ready) begin
                    state_d   = RESP;
                    m_valid_d = 1'b0;
                    m_wstrb_d = '0;
                    if (last_grant_q == PORT_D) begin
                        d_rdata_d = m_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_I;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench for vigna_bus_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus; expected outputs are hand-computed per cycle.
module tb_vigna_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_valid;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;

    logic        rr_i_ready, rr_d_ready, rr_m_valid;
    logic [31:0] rr_i_rdata, rr_d_rdata, rr_m_addr, rr_m_wdata;
    logic [3:0]  rr_m_wstrb;
    logic        fp_i_ready, fp_d_ready, fp_m_valid;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_m_addr, fp_m_wdata;
    logic [3:0]  fp_m_wstrb;

    int n_cmp = 0;
    int n_err = 0;

    vigna_bus_arbiter #(.ROUND_ROBIN(1), .ADDR_WIDTH(32)) u_rr (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(rr_i_ready), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_rdata(rr_i_rdata),
        .d_valid(d_valid), .d_ready(rr_d_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(rr_d_rdata),
        .m_valid(rr_m_valid), .m_ready(m_ready), .m_addr(rr_m_addr),
        .m_wdata(rr_m_wdata), .m_wstrb(rr_m_wstrb), .m_rdata(m_rdata)
    );

    vigna_bus_arbiter #(.ROUND_ROBIN(0), .ADDR_WIDTH(32)) u_fp (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_ready(fp_i_ready), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_rdata(fp_i_rdata),
        .d_valid(d_valid), .d_ready(fp_d_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(fp_d_rdata),
        .m_valid(fp_m_valid), .m_ready(m_ready), .m_addr(fp_m_addr),
        .m_wdata(fp_m_wdata), .m_wstrb(fp_m_wstrb), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        resetn;
        logic        i_valid;
        logic [31:0] i_addr;
        logic        d_valid;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wstrb;
        logic        m_ready;
        logic [31:0] m_rdata;
    } in_t;

    typedef struct packed {
        logic        m_valid;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_wstrb;
        logic        i_ready;
        logic        d_ready;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    vec_t vecs[$];

    function automatic in_t mk_in(logic rst, logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                                  logic [31:0] dw, logic [3:0] ds, logic mr, logic [31:0] md);
        in_t x;
        x.resetn = rst; x.i_valid = iv; x.i_addr = ia; x.d_valid = dv; x.d_addr = da;
        x.d_wdata = dw; x.d_wstrb = ds; x.m_ready = mr; x.m_rdata = md;
        return x;
    endfunction

    function automatic out_t mk_out(logic mv, logic [31:0] ma, logic [31:0] mw, logic [3:0] ms,
                                    logic ir, logic dr, logic [31:0] ird, logic [31:0] drd);
        out_t o;
        o.m_valid = mv; o.m_addr = ma; o.m_wdata = mw; o.m_wstrb = ms;
        o.i_ready = ir; o.d_ready = dr; o.i_rdata = ird; o.d_rdata = drd;
        return o;
    endfunction

    task automatic add(input in_t x, input out_t o);
        vec_t v;
        v.stim = x;
        v.exp  = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t x);
        resetn = x.resetn; i_valid = x.i_valid; i_addr = x.i_addr;
        d_valid = x.d_valid; d_addr = x.d_addr; d_wdata = x.d_wdata; d_wstrb = x.d_wstrb;
        m_ready = x.m_ready; m_rdata = x.m_rdata;
    endtask

    function automatic out_t get_out(input bit fp);
        if (fp)
            return mk_out(fp_m_valid, fp_m_addr, fp_m_wdata, fp_m_wstrb,
                          fp_i_ready, fp_d_ready, fp_i_rdata, fp_d_rdata);
        return mk_out(rr_m_valid, rr_m_addr, rr_m_wdata, rr_m_wstrb,
                      rr_i_ready, rr_d_ready, rr_i_rdata, rr_d_rdata);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input out_t a, input out_t e);
        chk({tag, ".m_valid"}, 32'(a.m_valid), 32'(e.m_valid));
        chk({tag, ".m_addr"},  a.m_addr,  e.m_addr);
        chk({tag, ".m_wdata"}, a.m_wdata, e.m_wdata);
        chk({tag, ".m_wstrb"}, 32'(a.m_wstrb), 32'(e.m_wstrb));
        chk({tag, ".i_ready"}, 32'(a.i_ready), 32'(e.i_ready));
        chk({tag, ".d_ready"}, 32'(a.d_ready), 32'(e.d_ready));
        chk({tag, ".i_rdata"}, a.i_rdata, e.i_rdata);
        chk({tag, ".d_rdata"}, a.d_rdata, e.d_rdata);
    endtask

    // Advance one edge, then check the one-hot ready invariant on both instances.
    task automatic step();
        @(posedge clk);
        #1;
        chk("rr.ready_overlap", 32'(rr_i_ready && rr_d_ready), 32'd0);
        chk("fp.ready_overlap", 32'(fp_i_ready && fp_d_ready), 32'd0);
    endtask

    initial begin
        string tag;
        int    rises;
        logic  prev_mv;

        i_wdata = '0;
        i_wstrb = '0;
        drive(mk_in(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0));

        // Single fetch, store with five wait cycles, m_ready seen in IDLE, held-valid re-issue.
        add(mk_in(0, 0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h0,  32'h0));
        add(mk_in(1, 1, 32'h100, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(1, 32'h100,  32'h0,        4'h0, 0, 0, 32'h0,  32'h0));
        add(mk_in(1, 1, 32'h100, 0, 32'h0,    32'h0,        4'h0, 1, 32'h13),       mk_out(0, 32'h100,  32'h0,        4'h0, 1, 0, 32'h13, 32'h0));
        add(mk_in(1, 1, 32'h100, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(0, 32'h100,  32'h0,        4'h0, 0, 0, 32'h13, 32'h0));
        add(mk_in(1, 0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(0, 32'h100,  32'h0,        4'h0, 0, 0, 32'h13, 32'h0));
        add(mk_in(1, 0, 32'h0,   1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0),        mk_out(1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 0, 32'h13, 32'h0));
        for (int i = 0; i < 5; i++)
            add(mk_in(1, 0, 32'h0, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0),      mk_out(1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 0, 32'h13, 32'h0));
        add(mk_in(1, 0, 32'h0,   1, 32'h2004, 32'hDEADBEEF, 4'h3, 1, 32'hCAFE0000), mk_out(0, 32'h2004, 32'hDEADBEEF, 4'h0, 0, 1, 32'h13, 32'hCAFE0000));
        add(mk_in(1, 0, 32'h0,   1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0),        mk_out(0, 32'h2004, 32'hDEADBEEF, 4'h0, 0, 0, 32'h13, 32'hCAFE0000));
        add(mk_in(1, 0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(0, 32'h2004, 32'hDEADBEEF, 4'h0, 0, 0, 32'h13, 32'hCAFE0000));
        add(mk_in(1, 1, 32'h104, 0, 32'h0,    32'h0,        4'h0, 1, 32'h55),       mk_out(1, 32'h104,  32'h0,        4'h0, 0, 0, 32'h13, 32'hCAFE0000));
        add(mk_in(1, 1, 32'h104, 0, 32'h0,    32'h0,        4'h0, 1, 32'h77),       mk_out(0, 32'h104,  32'h0,        4'h0, 1, 0, 32'h77, 32'hCAFE0000));
        add(mk_in(1, 1, 32'h104, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(0, 32'h104,  32'h0,        4'h0, 0, 0, 32'h77, 32'hCAFE0000));
        add(mk_in(1, 1, 32'h104, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(1, 32'h104,  32'h0,        4'h0, 0, 0, 32'h77, 32'hCAFE0000));
        add(mk_in(1, 1, 32'h104, 0, 32'h0,    32'h0,        4'h0, 1, 32'h99),       mk_out(0, 32'h104,  32'h0,        4'h0, 1, 0, 32'h99, 32'hCAFE0000));
        add(mk_in(1, 0, 32'h0,   0, 32'h0,    32'h0,        4'h0, 0, 32'h0),        mk_out(0, 32'h104,  32'h0,        4'h0, 0, 0, 32'h99, 32'hCAFE0000));

        foreach (vecs[k]) begin
            drive(vecs[k].stim);
            step();
            tag = $sformatf("vec%0d.rr", k);
            chk_out(tag, get_out(1'b0), vecs[k].exp);
            tag = $sformatf("vec%0d.fp", k);
            chk_out(tag, get_out(1'b1), vecs[k].exp);
        end

        // Contention from reset: RR alternates D,I,D,I; fixed priority always picks D.
        drive(mk_in(0, 0, '0, 0, '0, '0, '0, 0, '0));
        step();
        drive(mk_in(1, 1, 32'h1000, 1, 32'h2000, 32'h0, 4'h0, 0, 32'h0));
        for (int k = 0; k < 4; k++) begin
            logic rr_d;
            rr_d = (k % 2 == 0);
            m_ready = 1'b0;
            step();
            chk($sformatf("cont%0d.rr.m_valid", k), 32'(rr_m_valid), 32'd1);
            chk($sformatf("cont%0d.rr.m_addr", k), rr_m_addr, rr_d ? 32'h2000 : 32'h1000);
            chk($sformatf("cont%0d.fp.m_addr", k), fp_m_addr, 32'h2000);
            m_ready = 1'b1;
            m_rdata = 32'hA0 + 32'(k);
            step();
            chk($sformatf("cont%0d.rr.d_ready", k), 32'(rr_d_ready), 32'(rr_d));
            chk($sformatf("cont%0d.rr.i_ready", k), 32'(rr_i_ready), 32'(!rr_d));
            chk($sformatf("cont%0d.rr.rdata", k), rr_d ? rr_d_rdata : rr_i_rdata, 32'hA0 + 32'(k));
            chk($sformatf("cont%0d.fp.d_ready", k), 32'(fp_d_ready), 32'd1);
            chk($sformatf("cont%0d.fp.i_ready", k), 32'(fp_i_ready), 32'd0);
            chk($sformatf("cont%0d.fp.d_rdata", k), fp_d_rdata, 32'hA0 + 32'(k));
            m_ready = 1'b0;
            step();
            chk($sformatf("cont%0d.rr.idle_m_valid", k), 32'(rr_m_valid), 32'd0);
        end
        d_valid = 1'b0;
        step();
        chk("fp_i_only.m_addr", fp_m_addr, 32'h1000);
        chk("rr_i_only.m_addr", rr_m_addr, 32'h1000);
        m_ready = 1'b1;
        m_rdata = 32'hB0;
        step();
        chk("fp_i_only.i_ready", 32'(fp_i_ready), 32'd1);
        chk("fp_i_only.i_rdata", fp_i_rdata, 32'hB0);
        i_valid = 1'b0;
        m_ready = 1'b0;
        step();

        // Reset during REQ abandons the transaction; a fresh fetch then runs normally.
        drive(mk_in(1, 1, 32'h300, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0));
        step();
        chk("rst_mid.req_m_valid", 32'(rr_m_valid), 32'd1);
        step();
        resetn = 1'b0;
        step();
        chk_out("rst_mid.rr", get_out(1'b0), mk_out(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0));
        resetn = 1'b1;
        i_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_mid.no_ready%0d", k), 32'(rr_i_ready || rr_d_ready), 32'd0);
            chk($sformatf("rst_mid.no_mvalid%0d", k), 32'(rr_m_valid), 32'd0);
        end
        m_ready = 1'b0;
        i_valid = 1'b1;
        i_addr  = 32'h400;
        step();
        chk("rst_after.m_addr", rr_m_addr, 32'h400);
        m_ready = 1'b1;
        m_rdata = 32'h1234;
        step();
        chk("rst_after.i_ready", 32'(rr_i_ready), 32'd1);
        chk("rst_after.i_rdata", rr_i_rdata, 32'h1234);
        m_ready = 1'b0;
        step();
        i_valid = 1'b0;
        step();

        // Slow memory: m_* held for 10 wait cycles, exactly one m_valid assertion.
        rises   = 0;
        prev_mv = rr_m_valid;
        drive(mk_in(1, 0, 32'h0, 1, 32'h500, 32'h0, 4'h0, 0, 32'h0));
        for (int c = 0; c < 16; c++) begin
            m_ready = (c == 11);
            m_rdata = 32'h5150;
            if (c >= 13) d_valid = 1'b0;
            step();
            if (rr_m_valid && !prev_mv) rises++;
            prev_mv = rr_m_valid;
            if (c < 11) begin
                chk($sformatf("slow%0d.m_valid", c), 32'(rr_m_valid), 32'd1);
                chk($sformatf("slow%0d.m_addr", c), rr_m_addr, 32'h500);
            end
            chk($sformatf("slow%0d.d_ready", c), 32'(rr_d_ready), 32'(c == 11));
        end
        chk("slow.d_rdata", rr_d_rdata, 32'h5150);
        chk("slow.m_valid_rises", 32'(rises), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
